// File: rtl/axi_sram_slave.sv
// axi_sram_slave: AXI3 SRAM slave with a 2-deep in-order read queue, one write burst in flight and programmable read latency.
module axi_sram_slave #(
  parameter int ADDR_WIDTH = 16,
  parameter int RD_LAT     = 2
) (
  input  logic        aclk,
  input  logic        aresetn,
  input  logic [3:0]  arid,
  input  logic [31:0] araddr,
  input  logic [7:0]  arlen,
  input  logic [2:0]  arsize,
  input  logic [1:0]  arburst,
  input  logic [1:0]  arlock,
  input  logic [3:0]  arcache,
  input  logic [2:0]  arprot,
  input  logic        arvalid,
  output logic        arready,
  output logic [3:0]  rid,
  output logic [31:0] rdata,
  output logic [1:0]  rresp,
  output logic        rlast,
  output logic        rvalid,
  input  logic        rready,
  input  logic [3:0]  awid,
  input  logic [31:0] awaddr,
  input  logic [7:0]  awlen,
  input  logic [2:0]  awsize,
  input  logic [1:0]  awburst,
  input  logic [1:0]  awlock,
  input  logic [3:0]  awcache,
  input  logic [2:0]  awprot,
  input  logic        awvalid,
  output logic        awready,
  input  logic [3:0]  wid,
  input  logic [31:0] wdata,
  input  logic [3:0]  wstrb,
  input  logic        wlast,
  input  logic        wvalid,
  output logic        wready,
  output logic [3:0]  bid,
  output logic [1:0]  bresp,
  output logic        bvalid,
  input  logic        bready
);
  localparam int AW = ADDR_WIDTH;
  typedef logic [AW-1:0] waddr_t;
  typedef enum logic [1:0] {R_IDLE, R_WAIT, R_BEAT} r_state_t;
  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
  logic [31:0] mem [2**AW];
  logic [3:0]  q_id   [2];
  waddr_t      q_addr [2];
  logic [7:0]  q_len  [2];
  logic        wr_ptr, rd_ptr;
  logic [1:0]  q_cnt;
  r_state_t    r_state, r_next;
  w_state_t    w_state, w_next;
  waddr_t      r_addr, w_addr, pop_addr;
  logic [7:0]  r_len, r_beat, lat_cnt, pop_len;
  logic [3:0]  pop_id;
  logic        ar_hs, r_hs, w_hs, pop, bypass, load_first;
  logic        unused;
  assign unused = ^{arsize, arburst, arlock, arcache, arprot, awsize, awburst, awlock, awcache, awprot,
                    wid, awlen, araddr[31:AW+2], araddr[1:0], awaddr[31:AW+2], awaddr[1:0]};
  assign arready = q_cnt != 2'd2;
  assign rvalid  = r_state == R_BEAT;
  assign rlast   = rvalid && (r_beat == r_len);
  assign rresp   = 2'b00;
  assign awready = w_state == W_IDLE;
  assign wready  = w_state == W_DATA;
  assign bvalid  = w_state == W_RESP;
  assign bresp   = 2'b00;
  assign ar_hs   = arvalid && arready;
  assign r_hs    = rvalid && rready;
  assign w_hs    = wvalid && wready;
  // The engine takes a new burst when idle or on its last beat; an empty queue forwards the incoming AR directly.
  assign pop      = (r_state == R_IDLE || (r_hs && rlast)) && (q_cnt != 2'd0 || ar_hs);
  assign bypass   = pop && q_cnt == 2'd0;
  assign pop_id   = bypass ? arid : q_id[rd_ptr];
  assign pop_addr = bypass ? araddr[AW+1:2] : q_addr[rd_ptr];
  assign pop_len  = bypass ? arlen : q_len[rd_ptr];
  assign load_first = (pop && RD_LAT == 0) || (r_state == R_WAIT && lat_cnt == 8'd0);
  always_ff @(posedge aclk) begin
    if (ar_hs && !bypass) begin
      q_id[wr_ptr]   <= arid;
      q_addr[wr_ptr] <= araddr[AW+1:2];
      q_len[wr_ptr]  <= arlen;
    end
  end
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      q_cnt  <= 2'd0;
    end else begin
      if (ar_hs && !bypass) wr_ptr <= !wr_ptr;
      if (pop && !bypass) rd_ptr <= !rd_ptr;
      q_cnt <= q_cnt + 2'(ar_hs && !bypass) - 2'(pop && !bypass);
    end
  end
  always_comb begin
    r_next = r_state;
    if (pop) r_next = RD_LAT == 0 ? R_BEAT : R_WAIT;
    else if (r_state == R_WAIT && lat_cnt == 8'd0) r_next = R_BEAT;
    else if (r_hs && rlast) r_next = R_IDLE;
  end
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_state <= R_IDLE;
      r_addr  <= '0;
      r_len   <= 8'd0;
      r_beat  <= 8'd0;
      lat_cnt <= 8'd0;
      rid     <= 4'd0;
      rdata   <= 32'd0;
    end else begin
      r_state <= r_next;
      if (pop) begin
        r_addr  <= pop_addr;
        r_len   <= pop_len;
        rid     <= pop_id;
        r_beat  <= 8'd0;
        lat_cnt <= 8'(RD_LAT - 1);
      end else if (r_state == R_WAIT) lat_cnt <= lat_cnt - 8'd1;
      if (r_hs && !rlast) begin
        r_addr <= r_addr + waddr_t'(1);
        r_beat <= r_beat + 8'd1;
      end
      if (load_first) rdata <= mem[pop ? pop_addr : r_addr];
      else if (r_hs && !rlast) rdata <= mem[r_addr + waddr_t'(1)];
    end
  end
  always_comb begin
    w_next = w_state;
    if (awvalid && awready) w_next = W_DATA;
    else if (w_hs && wlast) w_next = W_RESP;
    else if (bvalid && bready) w_next = W_IDLE;
  end
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      w_state <= W_IDLE;
      w_addr  <= '0;
      bid     <= 4'd0;
    end else begin
      w_state <= w_next;
      if (awvalid && awready) begin
        w_addr <= awaddr[AW+1:2];
        bid    <= awid;
      end else if (w_hs) w_addr <= w_addr + waddr_t'(1);
    end
  end
  // Memory has no reset so preloaded contents survive aresetn.
  always_ff @(posedge aclk) begin
    if (w_hs)
      for (int b = 0; b < 4; b++)
        if (wstrb[b]) mem[w_addr][8*b +: 8] <= wdata[8*b +: 8];
  end
endmodule

// File: tb/tb_axi_sram_slave.sv
// tb_axi_sram_slave: directed self-checking bench; inputs driven and outputs sampled on the falling edge.
module tb_axi_sram_slave;
  logic        aclk, aresetn;
  logic [3:0]  arid, rid, awid, bid;
  logic [31:0] araddr, rdata, awaddr, wdata;
  logic [7:0]  arlen, awlen;
  logic [1:0]  rresp, bresp;
  logic [3:0]  wstrb;
  logic        arvalid, arready, rlast, rvalid, rready, awvalid, awready;
  logic        wlast, wvalid, wready, bvalid, bready;
  int          errors, checks;

  axi_sram_slave #(.ADDR_WIDTH(16), .RD_LAT(2)) dut (
    .aclk(aclk), .aresetn(aresetn),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(3'd2), .arburst(2'd1),
    .arlock(2'd0), .arcache(4'd0), .arprot(3'd0), .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(3'd2), .awburst(2'd1),
    .awlock(2'd0), .awcache(4'd0), .awprot(3'd0), .awvalid(awvalid), .awready(awready),
    .wid(4'd0), .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  task automatic axi_write(input logic [31:0] addr, input logic [31:0] d0, input int n);
    int t;
    bit to;
    to = 0;
    @(negedge aclk);
    awid = 4'h2; awaddr = addr; awlen = 8'(n - 1); awvalid = 1'b1;
    t = 0;
    while (!awready && t < 50) begin @(negedge aclk); t++; end
    to |= t >= 50;
    @(negedge aclk);
    awvalid = 1'b0;
    for (int i = 0; i < n; i++) begin
      wdata = d0 + 32'(i); wstrb = 4'hF; wlast = (i == n - 1); wvalid = 1'b1;
      t = 0;
      while (!wready && t < 50) begin @(negedge aclk); t++; end
      to |= t >= 50;
      @(negedge aclk);
    end
    wvalid = 1'b0; wlast = 1'b0; bready = 1'b1;
    t = 0;
    while (!bvalid && t < 50) begin @(negedge aclk); t++; end
    to |= t >= 50;
    @(negedge aclk);
    bready = 1'b0;
    checks++;
    if (to) begin errors++; $display("FAIL write_done addr=%h: timed out, required completion", addr); end
  endtask

  task automatic axi_read(input logic [31:0] addr, output logic [31:0] d);
    int t;
    @(negedge aclk);
    arid = 4'h0; araddr = addr; arlen = 8'd0; arvalid = 1'b1; rready = 1'b1;
    t = 0;
    while (!arready && t < 50) begin @(negedge aclk); t++; end
    @(negedge aclk);
    arvalid = 1'b0;
    t = 0;
    while (!rvalid && t < 50) begin @(negedge aclk); t++; end
    d = rvalid ? rdata : 32'hxxxxxxxx;
    @(negedge aclk);
    rready = 1'b0;
  endtask

  task automatic test_reset();
    aresetn = 1'b0;
    repeat (2) @(negedge aclk);
    checks++;
    if ({arready, awready, wready, rvalid, rlast, bvalid} !== 6'b110000) begin
      errors++; $display("FAIL rst_flags: got %b required 110000", {arready, awready, wready, rvalid, rlast, bvalid});
    end
    checks++;
    if ({rid, rdata, rresp} !== 38'd0) begin errors++; $display("FAIL rst_r: got %h/%h/%h required 0", rid, rdata, rresp); end
    checks++;
    if ({bid, bresp} !== 6'd0) begin errors++; $display("FAIL rst_b: got %h/%h required 0", bid, bresp); end
    aresetn = 1'b1;
    @(negedge aclk);
    checks++;
    if ({arready, awready, wready, rvalid, bvalid} !== 5'b11000) begin
      errors++; $display("FAIL rst_release: got %b required 11000", {arready, awready, wready, rvalid, bvalid});
    end
  endtask

  task automatic preload();
    axi_write(32'h100, 32'hDEADBEEF, 1);
    axi_write(32'h200, 32'hC0DE0080, 4);
    axi_write(32'h010, 32'hAAAAAAAA, 1);
    axi_write(32'h300, 32'h0BADF00D, 1);
  endtask

  task automatic test_single_read();
    @(negedge aclk);
    arid = 4'd0; araddr = 32'h100; arlen = 8'd0; arvalid = 1'b1; rready = 1'b1;
    checks++;
    if (arready !== 1'b1) begin errors++; $display("FAIL sr_arready: got %b required 1", arready); end
    @(negedge aclk);
    arvalid = 1'b0;
    for (int c = 1; c <= 2; c++) begin
      checks++;
      if (rvalid !== 1'b0) begin errors++; $display("FAIL sr_early T+%0d: rvalid got %b required 0", c, rvalid); end
      @(negedge aclk);
    end
    checks++;
    if ({rvalid, rlast, rid, rdata} !== {1'b1, 1'b1, 4'd0, 32'hDEADBEEF}) begin
      errors++; $display("FAIL sr_beat: got v=%b l=%b id=%h d=%h required v=1 l=1 id=0 d=deadbeef", rvalid, rlast, rid, rdata);
    end
    @(negedge aclk);
    rready = 1'b0;
    checks++;
    if (rvalid !== 1'b0) begin errors++; $display("FAIL sr_done: rvalid got %b required 0", rvalid); end
  endtask

  task automatic test_burst_backpressure();
    int k, cyc;
    bit tog;
    @(negedge aclk);
    arid = 4'd1; araddr = 32'h200; arlen = 8'd3; arvalid = 1'b1; rready = 1'b0;
    @(negedge aclk);
    arvalid = 1'b0;
    k = 0; cyc = 0; tog = 1'b1;
    while (k < 4 && cyc < 60) begin
      @(negedge aclk);
      cyc++;
      if (rvalid) begin
        rready = tog;
        tog = !tog;
        checks++;
        if ({rid, rdata, rlast} !== {4'd1, 32'hC0DE0080 + 32'(k), k == 3}) begin
          errors++; $display("FAIL bb_beat%0d: got id=%h d=%h l=%b required id=1 d=%h l=%b", k, rid, rdata, rlast, 32'hC0DE0080 + 32'(k), k == 3);
        end
        if (rready) k++;
      end else rready = 1'b0;
    end
    checks++;
    if (k !== 4) begin errors++; $display("FAIL bb_count: got %0d beats required 4", k); end
    @(negedge aclk);
    rready = 1'b0;
    checks++;
    if (rvalid !== 1'b0) begin errors++; $display("FAIL bb_done: rvalid got %b required 0", rvalid); end
  endtask

  task automatic test_fifo_full();
    logic [3:0]  ids  [4] = '{4'd0, 4'd1, 4'd1, 4'd0};
    logic [31:0] dats [4] = '{32'hDEADBEEF, 32'hC0DE0080, 32'hC0DE0081, 32'hC0DE0083};
    logic        lsts [4] = '{1'b1, 1'b0, 1'b1, 1'b1};
    logic [3:0]  req_id   [3] = '{4'd0, 4'd1, 4'd0};
    logic [31:0] req_addr [3] = '{32'h100, 32'h200, 32'h20C};
    logic [7:0]  req_len  [3] = '{8'd0, 8'd1, 8'd0};
    int k, cyc;
    rready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge aclk);
      arid = req_id[i]; araddr = req_addr[i]; arlen = req_len[i]; arvalid = 1'b1;
      checks++;
      if (arready !== 1'b1) begin errors++; $display("FAIL ff_accept%0d: arready got %b required 1", i, arready); end
    end
    @(negedge aclk);
    arvalid = 1'b0;
    checks++;
    if (arready !== 1'b0) begin errors++; $display("FAIL ff_full: arready got %b required 0", arready); end
    @(negedge aclk);
    checks++;
    if ({arready, rvalid, rid} !== {1'b0, 1'b1, 4'd0}) begin
      errors++; $display("FAIL ff_stall: got ar=%b rv=%b id=%h required ar=0 rv=1 id=0", arready, rvalid, rid);
    end
    rready = 1'b1;
    k = 0; cyc = 0;
    while (k < 4 && cyc < 60) begin
      if (rvalid) begin
        checks++;
        if ({rid, rdata, rlast} !== {ids[k], dats[k], lsts[k]}) begin
          errors++; $display("FAIL ff_beat%0d: got id=%h d=%h l=%b required id=%h d=%h l=%b", k, rid, rdata, rlast, ids[k], dats[k], lsts[k]);
        end
        k++;
      end
      @(negedge aclk);
      cyc++;
      if (cyc == 1) begin
        checks++;
        if (arready !== 1'b1) begin errors++; $display("FAIL ff_reassert: arready got %b required 1", arready); end
      end
    end
    rready = 1'b0;
    checks++;
    if (k !== 4) begin errors++; $display("FAIL ff_count: got %0d beats required 4", k); end
  endtask

  task automatic test_byte_write();
    logic [31:0] d;
    @(negedge aclk);
    awid = 4'd5; awaddr = 32'h10; awlen = 8'd0; awvalid = 1'b1;
    @(negedge aclk);
    awvalid = 1'b0;
    checks++;
    if ({awready, wready} !== 2'b01) begin errors++; $display("FAIL bw_aw: got awready=%b wready=%b required 0/1", awready, wready); end
    wdata = 32'h11223344; wstrb = 4'b0101; wlast = 1'b1; wvalid = 1'b1;
    @(negedge aclk);
    wvalid = 1'b0; wlast = 1'b0;
    checks++;
    if ({wready, bvalid, bid, bresp} !== {1'b0, 1'b1, 4'd5, 2'd0}) begin
      errors++; $display("FAIL bw_b: got wr=%b bv=%b bid=%h bresp=%h required 0/1/5/0", wready, bvalid, bid, bresp);
    end
    bready = 1'b1;
    @(negedge aclk);
    bready = 1'b0;
    checks++;
    if ({awready, bvalid} !== 2'b10) begin errors++; $display("FAIL bw_idle: got awready=%b bvalid=%b required 1/0", awready, bvalid); end
    axi_read(32'h10, d);
    checks++;
    if (d !== 32'hAA22AA44) begin errors++; $display("FAIL bw_data: got %h required aa22aa44", d); end
  endtask

  task automatic test_concurrent();
    logic [31:0] d;
    @(negedge aclk);
    awid = 4'd6; awaddr = 32'h300; awlen = 8'd0; awvalid = 1'b1;
    arid = 4'd1; araddr = 32'h300; arlen = 8'd0; arvalid = 1'b1; rready = 1'b0;
    checks++;
    if ({arready, awready} !== 2'b11) begin errors++; $display("FAIL cc_accept: got ar=%b aw=%b required 1/1", arready, awready); end
    @(negedge aclk);
    awvalid = 1'b0; arvalid = 1'b0;
    @(negedge aclk);
    wdata = 32'h5A5A5A5A; wstrb = 4'hF; wlast = 1'b1; wvalid = 1'b1;
    @(negedge aclk);
    wvalid = 1'b0; wlast = 1'b0;
    checks++;
    if ({rvalid, rid, rdata} !== {1'b1, 4'd1, 32'h0BADF00D}) begin
      errors++; $display("FAIL cc_old: got rv=%b id=%h d=%h required 1/1/0badf00d", rvalid, rid, rdata);
    end
    checks++;
    if ({bvalid, bid} !== {1'b1, 4'd6}) begin errors++; $display("FAIL cc_b: got bv=%b bid=%h required 1/6", bvalid, bid); end
    bready = 1'b1;
    @(negedge aclk);
    bready = 1'b0;
    checks++;
    if ({bvalid, rvalid, rdata} !== {1'b0, 1'b1, 32'h0BADF00D}) begin
      errors++; $display("FAIL cc_indep: got bv=%b rv=%b d=%h required 0/1/0badf00d", bvalid, rvalid, rdata);
    end
    rready = 1'b1;
    @(negedge aclk);
    rready = 1'b0;
    axi_read(32'h300, d);
    checks++;
    if (d !== 32'h5A5A5A5A) begin errors++; $display("FAIL cc_new: got %h required 5a5a5a5a", d); end
  endtask

  task automatic test_reset_mid();
    logic [31:0] d;
    @(negedge aclk);
    awid = 4'd3; awaddr = 32'h304; awlen = 8'd3; awvalid = 1'b1;
    @(negedge aclk);
    awvalid = 1'b0;
    wdata = 32'h77665544; wstrb = 4'hF; wlast = 1'b0; wvalid = 1'b1;
    @(negedge aclk);
    wvalid = 1'b0;
    arid = 4'd0; araddr = 32'h200; arlen = 8'd3; arvalid = 1'b1; rready = 1'b1;
    @(negedge aclk);
    arvalid = 1'b0;
    repeat (3) @(negedge aclk);
    checks++;
    if ({rvalid, rdata, rlast, wready} !== {1'b1, 32'hC0DE0081, 1'b0, 1'b1}) begin
      errors++; $display("FAIL rm_beat1: got rv=%b d=%h l=%b wr=%b required 1/c0de0081/0/1", rvalid, rdata, rlast, wready);
    end
    #2 aresetn = 1'b0;
    #1;
    checks++;
    if ({rvalid, rlast, wready, bvalid, rdata} !== 36'd0) begin
      errors++; $display("FAIL rm_drop: got rv=%b l=%b wr=%b bv=%b d=%h required all 0", rvalid, rlast, wready, bvalid, rdata);
    end
    @(negedge aclk);
    rready = 1'b0;
    aresetn = 1'b1;
    @(negedge aclk);
    checks++;
    if ({arready, awready, wready, rvalid, bvalid} !== 5'b11000) begin
      errors++; $display("FAIL rm_release: got %b required 11000", {arready, awready, wready, rvalid, bvalid});
    end
    axi_read(32'h304, d);
    checks++;
    if (d !== 32'h77665544) begin errors++; $display("FAIL rm_mem_w: got %h required 77665544", d); end
    axi_read(32'h200, d);
    checks++;
    if (d !== 32'hC0DE0080) begin errors++; $display("FAIL rm_mem_r: got %h required c0de0080", d); end
  endtask

  initial begin
    errors = 0; checks = 0;
    aresetn = 1'b0;
    arid = '0; araddr = '0; arlen = '0; arvalid = 1'b0; rready = 1'b0;
    awid = '0; awaddr = '0; awlen = '0; awvalid = 1'b0;
    wdata = '0; wstrb = '0; wlast = 1'b0; wvalid = 1'b0; bready = 1'b0;
    test_reset();
    preload();
    test_single_read();
    test_burst_backpressure();
    test_fifo_full();
    test_byte_write();
    test_concurrent();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/axi_sram_slave.md
# axi_sram_slave

AXI3 slave memory model that sits directly downstream of the CPU top's AXI master port and serves both instruction fetches (ID 0) and data accesses (ID 1) from one internal word-addressed SRAM array. It accepts up to two outstanding read bursts and one write burst at a time. It returns read beats after a programmable latency, with full AR/R/AW/W/B valid-ready handshakes. The block is the standard memory endpoint for CPU-level simulation and FPGA bring-up of the AXI-bridged pipeline.

## Interface
Parameters:
- ADDR_WIDTH, 16, word-index bits; the array holds 2^ADDR_WIDTH 32-bit words.
- RD_LAT, 2, idle cycles between popping a read request and presenting its first beat (0 allowed).

Ports:
- Clock and reset (already decided): one clock; reset is asynchronous and active-low.
  - aclk  in  1  clock.
  - aresetn  in  1  asynchronous active-low reset.
- AR channel:
  - arid  in  4  read ID.
  - araddr  in  32  byte address.
  - arlen  in  8  beats-1 (0..15 used).
  - arsize/arburst/arlock/arcache/arprot  in  3/2/2/4/3  ignored.
  - arvalid  in  1  request valid.
  - arready  out  1  request accepted.
- R channel:
  - rid  out  4  ID of the current beat.
  - rdata  out  32  read data.
  - rresp  out  2  always 0 (OKAY).
  - rlast  out  1  final beat.
  - rvalid  out  1  beat valid.
  - rready  in  1  master accepts the beat.
- AW channel: awid/awaddr/awlen  in  4/32/8; awsize/awburst/awlock/awcache/awprot  in  ignored; awvalid  in  1; awready  out  1.
- W channel: wid  in  4 (ignored); wdata  in  32; wstrb  in  4 byte enables; wlast  in  1; wvalid  in  1; wready  out  1.
- B channel: bid  out  4; bresp  out  2 (always 0); bvalid  out  1; bready  in  1.

## Operation
- Address mapping: word index = addr[ADDR_WIDTH+1:2]. Upper bits are ignored (aliasing). All bursts are treated as INCR, +1 word per beat, wrapping modulo 2^ADDR_WIDTH.
- Read path:
  - 2-entry AR FIFO holds {id, word index, len}. arready = FIFO not full. Push on arvalid&&arready.
  - Read engine states: R_IDLE, R_WAIT, R_BEAT.
  - R_IDLE: on FIFO non-empty, pop the head, load addr/len/id and the latency counter; go to R_WAIT (or R_BEAT directly if RD_LAT=0). rdata is loaded from mem[addr] on entry to R_BEAT.
  - R_WAIT: count down RD_LAT cycles, then go to R_BEAT.
  - R_BEAT: rvalid=1. rdata/rid/rlast hold stable while rvalid&&!rready. rlast = (beat == len).
    - On a handshake without rlast: addr+1, load the next word, stay in R_BEAT.
    - On a handshake with rlast: go to R_IDLE.
  - Responses are returned strictly in AR acceptance order regardless of ID.
- Write path:
  - States: W_IDLE, W_DATA, W_RESP.
  - W_IDLE: awready=1. On AW handshake, capture id/addr and go to W_DATA.
  - W_DATA: wready=1. Each W handshake writes the wstrb-selected bytes of wdata into mem[addr], then addr+1. The burst terminates on wlast only; awlen is not checked.
  - W_RESP: bvalid=1, bid = captured awid, bresp=0. Go to W_IDLE on bready.
- Read and write paths run independently. Concurrent AR and AW are both accepted in the same cycle.
- Memory coherence: a write commits at the clock edge ending its W handshake cycle. A read beat loaded at or after that edge sees the new data. If the same word is written and loaded in the same cycle, the read returns the old data.
- Reset (asynchronous, any time):
  - Clears the FIFO, both FSMs and all output registers.
  - In-flight bursts are dropped without response.
  - Memory contents are NOT cleared (preloaded via $readmemh in simulation).

## Timing
- Reset values: arready=1, awready=1, wready=0, rvalid=0, rlast=0, rid=0, rdata=0, rresp=0, bvalid=0, bid=0, bresp=0.
- Read latency: AR handshake in cycle T with the engine idle and FIFO empty gives first rvalid in cycle T+1+RD_LAT.
- Read beats: with rready held high, one beat per cycle. After the rlast handshake in cycle U, the next queued burst's rvalid appears in U+1+RD_LAT.
- arready deasserts the cycle after the second unpopped push. It re-asserts the cycle after a pop.
- Write timing: AW handshake in cycle T gives awready=0 and wready=1 from T+1. The wlast handshake in V gives wready=0 and bvalid=1 in V+1. awready returns the cycle after the B handshake.
- No combinational path from any input valid/ready to any output.

## Test plan
- Single read: preload mem[0x40]=0xDEADBEEF, RD_LAT=2; AR id=0 addr=0x100 len=0 at T -> rvalid at T+3, rdata=0xDEADBEEF, rid=0, rlast=1.
- Burst with backpressure: AR addr=0x200 len=3, rready toggling 1,0,1,0… -> 4 beats mem[0x80..0x83] in order, data held while rready=0, rlast only on the 4th beat.
- FIFO full: three ARs (id 0, 1, 0) back-to-back -> arready low after the second push, third accepted after the first pop; responses ordered id0, id1, id0.
- Byte write: AW addr=0x10, W wdata=0x11223344 wstrb=4'b0101 over old word 0xAAAAAAAA -> bvalid one cycle after W, bid=awid, subsequent read returns 0xAA22AA44.
- Concurrent access: AW+W to 0x300 and AR to 0x300 accepted in the same cycle -> read returns the pre-write value; a later read returns the new value; B response arrives independent of R.
- Reset mid-burst: deassert aresetn during the second beat of a len=3 read and during W_DATA -> all valids drop immediately, arready=awready=1 after release, memory keeps the values written before reset.
